// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. It merges D-stage data
// hazards, mult/div occupancy and exception/ERET redirection into pipeline controls.
module pipe_stall_ctrl #(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic [4:0]  e_dst,
  input  logic [4:0]  m_dst,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_is_md,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        m_exc_req,
  input  logic        m_bd,
  input  logic [31:0] m_pc,
  input  logic        m_eret,
  input  logic [31:0] epc_in,
  output logic        stall_fd,
  output logic        flush_e,
  output logic        flush_all,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        md_busy
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    REDIR   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic             rst_dly_q;

  logic redir_req;
  logic md_start;
  logic hz;
  logic md_hz;
  logic active;

  function automatic logic src_hz(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  assign redir_req = m_exc_req | m_eret;
  // A mult/div in E is younger than the faulting M instruction, so it must not start.
  assign md_start  = e_md_start & ~redir_req;

  assign hz = src_hz(d_rs, d_rs_tuse, e_dst, e_tnew) | src_hz(d_rs, d_rs_tuse, m_dst, m_tnew)
            | src_hz(d_rt, d_rt_tuse, e_dst, e_tnew) | src_hz(d_rt, d_rt_tuse, m_dst, m_tnew);

  assign md_hz  = d_is_md & ((md_cnt_q != '0) | e_md_start);
  assign active = ~reset & ~rst_dly_q;

  always_comb begin
    // NOTE: default first so every path assigns md_cnt_d and no latch is inferred.
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = e_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      md_cnt_q  <= '0;
      rst_dly_q <= 1'b1;
    end else begin
      rst_dly_q <= 1'b0;
      md_cnt_q  <= md_cnt_d;
      if (redir_req) begin
        state_q <= REDIR;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= md_start ? MD_BUSY : IDLE;
          MD_BUSY: state_q <= (md_cnt_d == '0) ? IDLE : MD_BUSY;
          REDIR:   state_q <= (md_cnt_d != '0) ? MD_BUSY : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Outputs are held low during reset and for one cycle after it.
  always_comb begin
    stall_fd    = 1'b0;
    flush_e     = 1'b0;
    flush_all   = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'd0;
    epc_we      = 1'b0;
    epc_out     = 32'd0;
    md_busy     = active & (md_cnt_q != '0);
    if (active) begin
      if (m_exc_req) begin
        flush_all   = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = EXC_VECTOR;
        epc_we      = 1'b1;
        epc_out     = m_bd ? (m_pc - 32'd4) : m_pc;
      end else if (m_eret) begin
        flush_all   = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = epc_in;
      end else if (state_q != REDIR) begin
        stall_fd = hz | md_hz;
        flush_e  = hz | md_hz;
      end
    end
  end

endmodule
